// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
// Single-port asynchronous SRAM controller (2K x 8). It accepts one host
// request at a time and sequences the active-low SRAM strobes with
// cycle-programmable setup, pulse, hold, access and turnaround phases.
// All outputs come directly from flops.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   req        in   host request, sampled only while ready=1
//   wr         in   1=write, 0=read, sampled with req
//   addr[10:0] in   host word address
//   wdata[7:0] in   host write data
//   ready      out  controller idle, able to accept req
//   done       out  one-cycle completion pulse
//   rdata[7:0] out  last read data, held until the next read completes
//   sram_addr  out  SRAM address
//   sram_dout  out  SRAM write data
//   sram_doe   out  tri-state enable for sram_dout onto the data bus
//   sram_din   in   SRAM data bus as read back
//   SRE        out  chip enable, active-low
//   SRG        out  output enable, active-low
//   SRW        out  write enable, active-low
// -----------------------------------------------------------------------------
module sram_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned WP_CYC    = 3,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned RD_CYC    = 5,
  parameter int unsigned TURN_CYC  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [10:0] addr,
  input  logic [7:0]  wdata,
  output logic        ready,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [10:0] sram_addr,
  output logic [7:0]  sram_dout,
  output logic        sram_doe,
  input  logic [7:0]  sram_din,
  output logic        SRE,
  output logic        SRG,
  output logic        SRW
);

  // Phase counters are loaded with (cycles - 1) on phase entry and the phase
  // ends on the edge where the counter reads zero. Out-of-range parameters
  // are clamped into 1..15 so the 4-bit counter can never wrap.
  function automatic logic [3:0] phase_load(input int unsigned cyc);
    logic [3:0] ld;
    if (cyc < 32'd1) begin
      ld = 4'd0;
    end else if (cyc > 32'd15) begin
      ld = 4'd14;
    end else begin
      ld = 4'(cyc - 32'd1);
    end
    return ld;
  endfunction

  localparam logic [3:0] SETUP_LD = phase_load(SETUP_CYC);
  localparam logic [3:0] WP_LD    = phase_load(WP_CYC);
  localparam logic [3:0] HOLD_LD  = phase_load(HOLD_CYC);
  localparam logic [3:0] RD_LD    = phase_load(RD_CYC);
  localparam logic [3:0] TURN_LD  = phase_load(TURN_CYC);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WSETUP  = 3'd1,
    WPULSE  = 3'd2,
    WHOLD   = 3'd3,
    RACCESS = 3'd4,
    RTURN   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        doe_q, doe_d;
  logic        sre_q, sre_d;
  logic        srg_q, srg_d;
  logic        srw_q, srw_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;
  logic        phase_end_s;

  assign phase_end_s = (cnt_q == 4'd0);

  // Next-state, phase counter, address/data latching and read capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          // Address and data are frozen here and stay put until the
          // controller returns to IDLE, covering setup and hold.
          addr_d = addr;
          dout_d = wdata;
          wr_d   = wr;
          if (wr) begin
            state_d = WSETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = RACCESS;
            cnt_d   = RD_LD;
          end
        end else begin
          state_d = IDLE;
        end
      end

      WSETUP: begin
        if (phase_end_s) begin
          state_d = WPULSE;
          cnt_d   = WP_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      WPULSE: begin
        if (phase_end_s) begin
          state_d = WHOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      WHOLD: begin
        if (phase_end_s) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          // Only a transfer that was latched as a write may report a write
          // completion.
          done_d  = wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RACCESS: begin
        if (phase_end_s) begin
          state_d = RTURN;
          cnt_d   = TURN_LD;
          // Sample the bus while SRG is still low on this edge.
          rdata_d = sram_din;
          done_d  = ~wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RTURN: begin
        if (phase_end_s) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Strobe and handshake decode from the next state so every output is a flop
  // that already reflects the phase being entered on this edge.
  always_comb begin
    sre_d   = 1'b1;
    srg_d   = 1'b1;
    srw_d   = 1'b1;
    doe_d   = 1'b0;
    ready_d = 1'b0;

    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
      end
      WSETUP: begin
        sre_d = 1'b0;
        doe_d = 1'b1;
      end
      WPULSE: begin
        sre_d = 1'b0;
        srw_d = 1'b0;
        doe_d = 1'b1;
      end
      WHOLD: begin
        sre_d = 1'b0;
        doe_d = 1'b1;
      end
      RACCESS: begin
        // Bus driver stays off whenever the SRAM may be driving the bus.
        sre_d = 1'b0;
        srg_d = 1'b0;
      end
      RTURN: begin
        ready_d = 1'b0;
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over any request or phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 11'd0;
      dout_q  <= 8'd0;
      rdata_q <= 8'd0;
      doe_q   <= 1'b0;
      sre_q   <= 1'b1;
      srg_q   <= 1'b1;
      srw_q   <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      doe_q   <= doe_d;
      sre_q   <= sre_d;
      srg_q   <= srg_d;
      srw_q   <= srw_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign sram_addr = addr_q;
  assign sram_dout = dout_q;
  assign sram_doe  = doe_q;
  assign SRE       = sre_q;
  assign SRG       = srg_q;
  assign SRW       = srw_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
// Self-checking bench for sram_ctrl: behavioural SRAM model, scoreboard of
// expected completions, directed phase checks and bus-safety monitors.
// -----------------------------------------------------------------------------
module tb_sram_ctrl;

  localparam int WP = 3;

  logic        clk;
  logic        reset;
  logic        req;
  logic        wr;
  logic [10:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic        done;
  logic [7:0]  rdata;
  logic [10:0] sram_addr;
  logic [7:0]  sram_dout;
  logic        sram_doe;
  logic [7:0]  sram_din;
  logic        SRE;
  logic        SRG;
  logic        SRW;

  sram_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .rdata     (rdata),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout),
    .sram_doe  (sram_doe),
    .sram_din  (sram_din),
    .SRE       (SRE),
    .SRG       (SRG),
    .SRW       (SRW)
  );

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [7:0]  data;
    int          done_cyc;
  } txn_t;

  txn_t       sb[$];
  logic [7:0] mem     [2048];
  logic [7:0] ref_mem [2048];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         wp_cnt = 0;
  int         setup_cnt = 0;
  int         commits = 0;
  logic       prev_srw = 1'b1;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM drives the bus only while selected and output-enabled.
  assign sram_din = (!SRE && !SRG) ? mem[sram_addr] : 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // SRAM model: commits on the SRW rising edge and checks write timing.
  always @(negedge clk) begin
    if (prev_srw && !SRW) begin
      check_eq("setup_cycles", setup_cnt, 1);
    end
    if (!SRW) begin
      wp_cnt++;
    end else begin
      if (!prev_srw && !reset) begin
        check_eq("wp_width", wp_cnt, WP);
        check_eq("hold_phase", {30'd0, SRE, sram_doe}, 32'd1);
        mem[sram_addr] = sram_dout;
        commits++;
      end
      wp_cnt = 0;
    end
    if (!SRE && SRW && sram_doe && prev_srw) setup_cnt++;
    else if (SRE) setup_cnt = 0;
    prev_srw = SRW;
  end

  // Bus-safety monitor.
  always @(negedge clk) begin
    check_eq("srg_doe_overlap", {31'd0, (!SRG && sram_doe)}, 32'd0);
    check_eq("srg_srw_overlap", {31'd0, (!SRG && !SRW)}, 32'd0);
  end

  // Scoreboard: pop one expected completion per done pulse.
  always @(negedge clk) begin
    txn_t t;
    if (done) begin
      if (sb.size() == 0) begin
        check_eq("done_unexpected", 32'd1, 32'd0);
      end else begin
        t = sb.pop_front();
        check_eq("done_latency", cyc, t.done_cyc);
        if (t.wr) ref_mem[t.addr] = t.data;
        else      check_eq("rdata", {24'd0, rdata}, {24'd0, ref_mem[t.addr]});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  // Present a request at a negedge where ready=1; returns at accept edge + 1.
  task automatic issue(input logic w, input logic [10:0] a, input logic [7:0] d,
                       input bit push, output int acc);
    txn_t t;
    wait_ready();
    req = 1'b1; wr = w; addr = a; wdata = d;
    acc = cyc + 1;
    if (push) begin
      t.wr = w; t.addr = a; t.data = d; t.done_cyc = cyc + 6;
      sb.push_back(t);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int prev_acc;
    int n;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    reset = 1'b1; req = 1'b0; wr = 1'b0; addr = 11'd0; wdata = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_strobes", {29'd0, SRE, SRG, SRW}, 32'd7);
    check_eq("rst_doe", {31'd0, sram_doe}, 32'd0);
    check_eq("rst_addr", {21'd0, sram_addr}, 32'd0);
    check_eq("rst_dout", {24'd0, sram_dout}, 32'd0);
    check_eq("rst_rdata", {24'd0, rdata}, 32'd0);

    // Directed write 0x155 <- 0xA5 with per-cycle strobe checks.
    issue(1'b1, 11'h155, 8'hA5, 1'b1, acc);
    req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_eq("wr_sre", {31'd0, SRE}, (k <= 5) ? 32'd0 : 32'd1);
      check_eq("wr_srw", {31'd0, SRW}, (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
      check_eq("wr_done", {31'd0, done}, (k == 6) ? 32'd1 : 32'd0);
      check_eq("wr_ready", {31'd0, ready}, (k == 6) ? 32'd1 : 32'd0);
      if (k <= 5) check_eq("wr_addr_stable", {21'd0, sram_addr}, 32'h155);
    end
    check_eq("mem_155", {24'd0, mem[11'h155]}, 32'hA5);

    // Directed read 0x155 with a stray write request held during the read.
    issue(1'b0, 11'h155, 8'h00, 1'b1, acc);
    wr = 1'b1; addr = 11'h7FF; wdata = 8'h3C;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check_eq("rd_srg", {31'd0, SRG}, (k <= 5) ? 32'd0 : 32'd1);
      check_eq("rd_sre", {31'd0, SRE}, (k <= 5) ? 32'd0 : 32'd1);
      check_eq("rd_done", {31'd0, done}, (k == 6) ? 32'd1 : 32'd0);
      check_eq("rd_ready", {31'd0, ready}, (k == 9) ? 32'd1 : 32'd0);
      if (k == 6) check_eq("rd_data", {24'd0, rdata}, 32'hA5);
      if (k == 8) req = 1'b0;
    end
    check_eq("stray_no_write", {24'd0, mem[11'h7FF]}, 32'h00);

    // Back-to-back writes with req held high.
    prev_acc = 0;
    for (int i = 0; i < 32; i++) begin
      issue(1'b1, 11'(i), ~8'(i), 1'b1, acc);
      if (i > 0) check_eq("b2b_period", acc - prev_acc, 32'd6);
      prev_acc = acc;
    end
    req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      issue(1'b0, 11'(i), 8'h00, 1'b1, acc);
      req = 1'b0;
    end

    // Reset in the middle of the write pulse.
    issue(1'b1, 11'h155, 8'h11, 1'b0, acc);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_srw", {31'd0, SRW}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_srw", {31'd0, SRW}, 32'd1);
    check_eq("mid_rst_sre", {31'd0, SRE}, 32'd1);
    check_eq("mid_rst_doe", {31'd0, sram_doe}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check_eq("post_rst_done", {31'd0, done}, 32'd0);
    end
    issue(1'b0, 11'h155, 8'h00, 1'b1, acc);
    req = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("sb_drained", sb.size(), 32'd0);
    check_eq("write_commits", commits, 32'd33);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter SETUP_CYC, 1, clock cycles of address/data setup with SRE low before SRW falls (20 ns at 50 MHz, ≥ TAVWL 10 ns).
REQ-002 Parameter WP_CYC, 3, clock cycles SRW held low (60 ns, ≥ TWLWH 55 ns).
REQ-003 Parameter HOLD_CYC, 1, clock cycles address/data held after SRW rises (20 ns, ≥ TWHDX 20 ns).
REQ-004 Parameter RD_CYC, 5, clock cycles SRE/SRG held low before read data is sampled (100 ns, ≥ TAVQV 90 ns).
REQ-005 Parameter TURN_CYC, 3, bus-turnaround cycles after a read before a new request is accepted (60 ns, ≥ TEHQZ 50 ns).
REQ-006 clk  input  1  system clock, 50 MHz nominal, all logic on rising edge.
REQ-007 reset  input  1  one clock; reset is synchronous and active-high.
REQ-008 req  input  1  host request, sampled only when ready=1.
REQ-009 wr  input  1  1=write, 0=read, sampled with req.
REQ-010 addr  input  11  host word address.
REQ-011 wdata  input  8  host write data.
REQ-012 ready  output  1  controller idle and able to accept req.
REQ-013 done  output  1  one-cycle completion pulse for read or write.
REQ-014 rdata  output  8  read data, valid while done=1 after a read, held until next read completes.
REQ-015 sram_addr  output  11  to SRAM Address.
REQ-016 sram_dout  output  8  write data to SRAM Data bus.
REQ-017 sram_doe  output  1  tri-state enable for sram_dout onto the bidirectional bus.
REQ-018 sram_din  input  8  SRAM Data bus as read back.
REQ-019 SRE  output  1  chip enable, active-low.
REQ-020 SRG  output  1  output enable, active-low.
REQ-021 SRW  output  1  write enable, active-low.

Function
REQ-022 All outputs SHALL be registered; counters 4 bits; every CYC parameter SHALL be in range 1..15.
REQ-023 FSM states: IDLE, WSETUP, WPULSE, WHOLD, RACCESS, RTURN; ready=1 only in IDLE.
REQ-024 In IDLE, req=1 SHALL latch addr/wdata/wr into sram_addr/sram_dout/internal flag on that edge; req while ready=0 SHALL be ignored (no queue).
REQ-025 Write: IDLE→WSETUP (SETUP_CYC cycles, SRE=0, SRW=1, SRG=1, sram_doe=1)→WPULSE (WP_CYC cycles, SRW=0)→WHOLD (HOLD_CYC cycles, SRW=1, SRE=0, sram_doe=1)→IDLE.
REQ-026 sram_addr and sram_dout SHALL remain stable from the accepting edge through the last WHOLD cycle.
REQ-027 On the WHOLD→IDLE edge: SRE=1, sram_doe=0, done=1 for exactly one cycle, ready=1 in that same cycle.
REQ-028 Read: IDLE→RACCESS (RD_CYC cycles, SRE=0, SRG=0, SRW=1, sram_doe=0)→RTURN (TURN_CYC cycles, SRE=1, SRG=1)→IDLE.
REQ-029 rdata SHALL capture sram_din on the RACCESS→RTURN edge; done=1 in the first RTURN cycle only.
REQ-030 sram_doe SHALL never be 1 while SRG=0, and SRG and SRW SHALL never both be 0.
REQ-031 Latency at defaults: write accept-to-done 6 edges, read accept-to-done 6 edges, read accept-to-ready 9 edges.
REQ-032 A req in the cycle done=1 following a write SHALL be accepted (back-to-back writes every 6 cycles).

Reset
REQ-033 When reset=1 at a rising edge, next state SHALL be IDLE with SRE=SRG=SRW=1, sram_doe=0, sram_addr=0, sram_dout=0, rdata=0, done=0, ready=1, regardless of current state.
REQ-034 Reset mid-write SHALL release SRW on that edge without issuing done; reset has priority over req.

Verification
REQ-035 Reset then write addr=0x155 wdata=0xA5 -> SRE low 5 cycles, SRW low cycles 2-4 after accept, done at edge 6, SRAM model mem[0x155]=0xA5, no timing-error message.
REQ-036 Read back 0x155 -> SRG/SRE low 5 cycles, done at edge 6 with rdata=0xA5, ready=1 at edge 9.
REQ-037 Back-to-back writes 0x000..0x01F data=~addr with req held high -> 32 writes, one per 6 cycles, all read back correct.
REQ-038 Assert req during RACCESS and RTURN -> ignored, no extra SRAM cycle, no done.
REQ-039 Assert reset during WPULSE -> SRW=1, SRE=1, sram_doe=0 on next edge, done stays 0, ready=1.
REQ-040 Monitor for all tests -> SRG=0 and sram_doe=1 never coincide; SRG=0 and SRW=0 never coincide.
